seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Downstream consumer of the binary-to-BCD stage in the clock/stopwatch design. It takes six BCD digits (HH:MM:SS) plus a load strobe and time-multiplexes them onto a 6-digit common-anode 7-segment display. It latches new values glitch-free at digit boundaries, blanks between digits to suppress ghosting, and can optionally blank the leading hour-tens zero.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (min 4)
GUARD, 16, cycles at start of each slot with all anodes off (must be < SCAN_DIV)
SEG_ACTIVE_LOW, 1, 1 = seg/dp driven low-true, 0 = high-true
AN_ACTIVE_LOW, 1, 1 = anodes low-true, 0 = high-true
BLINK_DIV, 25000000, clk cycles per blink half-period (used only with macro)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
load  input  1  one-cycle strobe: digits_in/dp_in valid (driven from converter done)
digits_in  input  24  six BCD nibbles; [3:0]=sec ones, [7:4]=sec tens, [11:8]=min ones, [15:12]=min tens, [19:16]=hr ones, [23:20]=hr tens
dp_in  input  6  decimal point per digit, same index order
blank_lz  input  1  1 = suppress digit 5 when its value is 0
blink_sel  input  3  one-hot field select: [0]=sec, [1]=min, [2]=hr (ignored without macro)
an  output  6  anode enables, an[i] drives digit i
seg  output  7  segments {g,f,e,d,c,b,a}
dp  output  1  decimal point of the active digit
frame_tick  output  1  one-cycle pulse on completion of a full 6-digit scan

Behaviour:
- Reset: an, seg and dp all at inactive level; frame_tick=0; prescaler=0; idx=0; display and pending registers=0; pend_valid=0. Reset is asynchronous on every register.
- Prescaler counts 0..SCAN_DIV-1 and then wraps; terminal cycle = boundary. At a boundary, idx advances 0->1->...->5->0.
- frame_tick is 1 for exactly the cycle after the boundary where idx wraps 5->0.
- Load: on load=1, digits_in/dp_in are captured into pending and pend_valid is set. At the next boundary the display register takes pending and pend_valid clears.
- load coincident with a boundary: the display register takes digits_in directly that cycle and pend_valid stays 0.
- Two loads within one slot: the last one wins.
- Displayed digits never change mid-slot.
- Output timing: registered, one clk after prescaler/idx.
- Guard: while prescaler < GUARD, all anodes are inactive. Otherwise an[idx] is active and all other anodes are inactive.
- Decoding (active-high form, gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Nibble values 10..15 display a dash (40).
- Polarity: the decoded value is inverted when SEG_ACTIVE_LOW=1; dp follows the same polarity.
- Leading-zero blank: when blank_lz=1, idx=5 and digit5==0, an stays inactive for the whole slot. seg is still driven.
- No output other than frame_tick is combinational from inputs.

Optional Feature:
SEG7_BLINK_EN
- Defined: a blink counter toggles a phase bit every BLINK_DIV cycles, reset phase=on. While phase=off, the anodes of the fields selected by blink_sel are held inactive. Field digits: sec = 0,1; min = 2,3; hr = 4,5. Used to flag the field being set.
- Undefined: no blink counter exists, blink_sel is unused, and display behaviour is identical to the defined case with blink_sel=0.

Test Plan:
1. Reset check (SCAN_DIV=4, GUARD=1): assert rst_n=0 mid-scan -> an=6'h3F, seg=7'h7F, dp=1 immediately; idx=0 after release.
2. Scan order: load digits_in=24'h123456, dp_in=0 -> digit slots 0..5 show seg (active-low) of 6,5,4,3,2,1 = 02,12,19,30,24,79; each an[i] is low for 3 of 4 cycles; frame_tick pulses once per 24 cycles.
3. Mid-slot load: load 24'h000000 two cycles into slot 2 -> slot 2 keeps showing 4 (19); slot 3 shows 0 (40). Load coincident with a boundary -> new value appears in that next slot.
4. Invalid BCD and dp: digits_in nibble 0 = 4'hC, dp_in=6'b000001 -> slot 0 seg=3F (dash, active-low), dp=0.
5. Leading zero: digits_in=24'h091500, blank_lz=1 -> an[5] never goes low. With blank_lz=0, an[5] goes low and shows 40.
6. SEG7_BLINK_EN (BLINK_DIV=8), blink_sel=3'b010 -> an[2] and an[3] are suppressed for alternating 8-cycle windows; other digits are unaffected. Without the macro the same stimulus leaves all digits scanning normally.

Source files
------------

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Time-multiplexes six BCD digits (HH:MM:SS) onto a 6-digit
//             7-segment display. New values are staged and only reach the
//             display at digit-slot boundaries, so a digit never changes
//             partway through its slot. Each slot opens with a short window
//             in which every anode is off, which suppresses ghosting. The
//             hour-tens digit can be blanked when it is zero.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1   system clock
//    rst_n       in   1   asynchronous active-low reset
//    load        in   1   one-cycle strobe, digits_in/dp_in valid
//    digits_in   in  24   six BCD nibbles, [3:0] = seconds ones ...
//                         [23:20] = hours tens
//    dp_in       in   6   decimal point per digit, same order as digits_in
//    blank_lz    in   1   1 = blank digit 5 while its value is 0
//    blink_sel   in   3   field select for blinking: [0]=sec [1]=min [2]=hr
//    an          out  6   anode enables, an[i] drives digit i
//    seg         out  7   segments {g,f,e,d,c,b,a}
//    dp          out  1   decimal point of the active digit
//    frame_tick  out  1   one-cycle pulse after each complete 6-digit scan
// ----------------------------------------------------------------------------
//  Build option
//    SEG7_BLINK_EN : when defined, a blink counter toggles an on/off phase
//                    every BLINK_DIV cycles; during the off phase the anodes
//                    of the fields picked by blink_sel are held inactive.
//                    When undefined there is no blink counter and blink_sel
//                    is ignored.
// ============================================================================
module seg7_scan_driver #(
  parameter int SCAN_DIV       = 50000,     // clk cycles per digit slot (>= 4)
  parameter int GUARD          = 16,        // all-off cycles at slot start (< SCAN_DIV)
  parameter int SEG_ACTIVE_LOW = 1,         // 1 = seg/dp low-true
  parameter int AN_ACTIVE_LOW  = 1,         // 1 = anodes low-true
  parameter int BLINK_DIV      = 25000000   // blink half-period in clk cycles
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [23:0] digits_in,
  input  logic [5:0]  dp_in,
  input  logic        blank_lz,
  input  logic [2:0]  blink_sel,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_presc_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(SCAN_DIV - 1);
  localparam logic [c_presc_w-1:0] c_presc_one  = c_presc_w'(1);
  localparam logic [c_presc_w-1:0] c_guard      = c_presc_w'(GUARD);

  localparam logic [2:0] c_idx_last = 3'd5;

  // Idle (inactive) levels of the display pins for the configured polarity
  localparam logic [5:0] c_an_off  = (AN_ACTIVE_LOW  != 0) ? 6'h3F : 6'h00;
  localparam logic [6:0] c_seg_off = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       c_dp_off  = (SEG_ACTIVE_LOW != 0);

  // --------------------------------------------------------------------------
  // Segment decoder, active-high gfedcba. Non-BCD nibbles show a dash.
  // --------------------------------------------------------------------------
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] v;
    v = 7'h40;
    case (nib)
      4'd0:    v = 7'h3F;
      4'd1:    v = 7'h06;
      4'd2:    v = 7'h5B;
      4'd3:    v = 7'h4F;
      4'd4:    v = 7'h66;
      4'd5:    v = 7'h6D;
      4'd6:    v = 7'h7D;
      4'd7:    v = 7'h07;
      4'd8:    v = 7'h7F;
      4'd9:    v = 7'h6F;
      default: v = 7'h40;
    endcase
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [c_presc_w-1:0] r_presc;
  logic [2:0]           r_idx;
  logic                 r_frame_tick;

  logic [23:0]          r_disp;
  logic [5:0]           r_disp_dp;
  logic [23:0]          r_pend;
  logic [5:0]           r_pend_dp;
  logic                 r_pend_valid;

  logic [5:0]           r_an;
  logic [6:0]           r_seg;
  logic                 r_dp;

  logic                 w_boundary;
  logic                 w_in_guard;
  logic                 w_lz_blank;
  logic [3:0]           w_cur_nib;
  logic                 w_cur_dp;
  logic [5:0]           w_an_onehot;
  logic [5:0]           w_blink_mask;
  logic [5:0]           w_an_act;
  logic [6:0]           w_seg_act;
  logic [5:0]           w_an_next;
  logic [6:0]           w_seg_next;
  logic                 w_dp_next;

  // --------------------------------------------------------------------------
  // Slot prescaler and digit index
  // --------------------------------------------------------------------------
  assign w_boundary = (r_presc == c_presc_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_boundary) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + c_presc_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 3'd0;
    end else if (w_boundary) begin
      r_idx <= (r_idx == c_idx_last) ? 3'd0 : r_idx + 3'd1;
    end
  end

  // Raised by the boundary that closes the digit-5 slot, so it is high for
  // the first cycle of the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_boundary && (r_idx == c_idx_last);
    end
  end

  // --------------------------------------------------------------------------
  // Load staging
  // A load lands in the pending register and is promoted at the next slot
  // boundary. A load that arrives exactly on a boundary bypasses pending and
  // goes straight into the display register, so it is seen in the slot that
  // starts right then. Later loads simply overwrite pending (last one wins).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp       <= 24'd0;
      r_disp_dp    <= 6'd0;
      r_pend       <= 24'd0;
      r_pend_dp    <= 6'd0;
      r_pend_valid <= 1'b0;
    end else if (w_boundary) begin
      if (load) begin
        r_disp    <= digits_in;
        r_disp_dp <= dp_in;
      end else if (r_pend_valid) begin
        r_disp    <= r_pend;
        r_disp_dp <= r_pend_dp;
      end
      r_pend_valid <= 1'b0;
    end else if (load) begin
      r_pend       <= digits_in;
      r_pend_dp    <= dp_in;
      r_pend_valid <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Current digit selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_cur_nib   = r_disp[3:0];
    w_cur_dp    = r_disp_dp[0];
    w_an_onehot = 6'b000001;
    case (r_idx)
      3'd0: begin
        w_cur_nib   = r_disp[3:0];
        w_cur_dp    = r_disp_dp[0];
        w_an_onehot = 6'b000001;
      end
      3'd1: begin
        w_cur_nib   = r_disp[7:4];
        w_cur_dp    = r_disp_dp[1];
        w_an_onehot = 6'b000010;
      end
      3'd2: begin
        w_cur_nib   = r_disp[11:8];
        w_cur_dp    = r_disp_dp[2];
        w_an_onehot = 6'b000100;
      end
      3'd3: begin
        w_cur_nib   = r_disp[15:12];
        w_cur_dp    = r_disp_dp[3];
        w_an_onehot = 6'b001000;
      end
      3'd4: begin
        w_cur_nib   = r_disp[19:16];
        w_cur_dp    = r_disp_dp[4];
        w_an_onehot = 6'b010000;
      end
      3'd5: begin
        w_cur_nib   = r_disp[23:20];
        w_cur_dp    = r_disp_dp[5];
        w_an_onehot = 6'b100000;
      end
      default: begin
        w_cur_nib   = r_disp[3:0];
        w_cur_dp    = r_disp_dp[0];
        w_an_onehot = 6'b000000;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Optional field blinking
  // --------------------------------------------------------------------------
`ifdef SEG7_BLINK_EN
  localparam int c_blink_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);
  localparam logic [c_blink_w-1:0] c_blink_one  = c_blink_w'(1);

  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 r_blink_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_blink_cnt == c_blink_last) begin
      r_blink_cnt <= '0;
      r_blink_on  <= ~r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + c_blink_one;
    end
  end

  // Each field covers two adjacent digits: sec = 0,1; min = 2,3; hr = 4,5
  assign w_blink_mask = r_blink_on ? 6'h00
                      : {{2{blink_sel[2]}}, {2{blink_sel[1]}}, {2{blink_sel[0]}}};
`else
  localparam int c_unused_blink_div = BLINK_DIV;
  logic w_unused_blink_sel;
  assign w_unused_blink_sel = ^blink_sel;
  assign w_blink_mask       = 6'h00;
`endif

  // --------------------------------------------------------------------------
  // Output formation
  // Leading-zero blanking only gates the anode; seg keeps its decoded value.
  // --------------------------------------------------------------------------
  assign w_in_guard = (r_presc < c_guard);
  assign w_lz_blank = blank_lz && (r_idx == c_idx_last) && (r_disp[23:20] == 4'd0);

  assign w_an_act  = (w_in_guard || w_lz_blank) ? 6'h00 : (w_an_onehot & ~w_blink_mask);
  assign w_seg_act = f_decode(w_cur_nib);

  assign w_an_next  = (AN_ACTIVE_LOW  != 0) ? ~w_an_act  : w_an_act;
  assign w_seg_next = (SEG_ACTIVE_LOW != 0) ? ~w_seg_act : w_seg_act;
  assign w_dp_next  = (SEG_ACTIVE_LOW != 0) ? ~w_cur_dp  : w_cur_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= c_an_off;
      r_seg <= c_seg_off;
      r_dp  <= c_dp_off;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Scoreboard bench for seg7_scan_driver (SCAN_DIV=4, GUARD=1,
//             active-low seg and anodes, BLINK_DIV=8). Expected outputs for
//             each cycle are queued by the stimulus process from a
//             slot-level model; a monitor pops and compares every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int D  = 4;   // slot length
  localparam int G  = 1;   // guard length
  localparam int BD = 8;   // blink half-period

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [23:0] digits_in = 24'd0;
  logic [5:0]  dp_in = 6'd0;
  logic        blank_lz = 1'b0;
  logic [2:0]  blink_sel = 3'd0;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  seg7_scan_driver #(
    .SCAN_DIV(D), .GUARD(G), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .blink_sel(blink_sel),
    .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [14:0] q[$];                       // {an, seg, dp, frame_tick}
  localparam logic [14:0] RST_OUT = {6'h3F, 7'h7F, 1'b1, 1'b0};

  // Model state: t counts cycles since reset release; the value shown in a
  // slot is the last load issued strictly before that slot began.
  int          t;
  logic [23:0] latest, shown;
  logic [5:0]  latest_dp, shown_dp;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (n < 4'd10) ? tbl[n] : 7'h40;
  endfunction

  // Outputs seen in cycle s+1, derived from the display state during cycle s
  function automatic logic [14:0] model(input int s, input logic [23:0] v,
                                        input logic [5:0] d, input logic blz,
                                        input logic [2:0] bsel);
    int p, i;
    logic [3:0] nib;
    logic [5:0] act;
    p   = s % D;
    i   = (s / D) % 6;
    nib = v[i*4 +: 4];
    act = 6'd0;
    if (p >= G && !(blz && i == 5 && v[23:20] == 4'd0)) act[i] = 1'b1;
`ifdef SEG7_BLINK_EN
    if (((s / BD) % 2) == 1) begin
      for (int k = 0; k < 6; k++) if (bsel[k/2]) act[k] = 1'b0;
    end
`else
    if (bsel == 3'b111) act = act;       // blink_sel has no effect in this build
`endif
    return {~act, ~glyph(nib), ~d[i], (((s + 1) % (6 * D)) == 0)};
  endfunction

  // Monitor: one comparison per cycle while out of reset
  initial begin
    logic [14:0] e, a;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n_cmp++;
        a = {an, seg, dp, frame_tick};
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_empty t=%0d actual=%h required=<entry>", $time, a);
        end else begin
          e = q.pop_front();
          if (a !== e) begin
            n_bad++;
            $display("FAIL cycle_out time=%0t actual an=%h seg=%h dp=%b ft=%b required an=%h seg=%h dp=%b ft=%b",
                     $time, a[14:9], a[8:2], a[1], a[0], e[14:9], e[8:2], e[1], e[0]);
          end
        end
      end
    end
  end

  task automatic check_reset();
    logic [14:0] a;
    a = {an, seg, dp, frame_tick};
    n_cmp++;
    if (a !== RST_OUT) begin
      n_bad++;
      $display("FAIL async_reset actual=%h required=%h", a, RST_OUT);
    end
  endtask

  // Called just after a rising edge; ends just after the next one.
  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    #1;
    check_reset();
    q.delete();
    t = 0; latest = '0; shown = '0; latest_dp = '0; shown_dp = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    q.push_back(RST_OUT);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic ld, input logic [23:0] v, input logic [5:0] d);
    if (t % D == 0) begin
      shown    = latest;
      shown_dp = latest_dp;
    end
    load      = ld;
    digits_in = ld ? v : digits_in;
    dp_in     = ld ? d : dp_in;
    q.push_back(model(t, shown, shown_dp, blank_lz, blink_sel));
    if (ld) begin
      latest    = v;
      latest_dp = d;
    end
    t++;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 24'd0, 6'd0);
  endtask

  task automatic idle_until(input int modulus, input int phase);
    for (int k = 0; k < 100 && (t % modulus) != phase; k++) step(1'b0, 24'd0, 6'd0);
  endtask

  initial begin
    logic [23:0] rv;
    #2;
    @(posedge clk); #1;
    do_reset();
    idle(8);

    // Scan order 6,5,4,3,2,1
    step(1'b1, 24'h123456, 6'd0);
    idle(30);

    // Load two cycles into slot 2: slot 2 keeps its digit
    idle_until(6 * D, 2 * D + 2);
    step(1'b1, 24'h000000, 6'd0);
    idle(12);

    // Load on a boundary cycle: visible in the very next slot
    idle_until(D, D - 1);
    step(1'b1, 24'h654321, 6'd0);
    idle(8);

    // Two loads within one slot: last wins
    idle_until(D, 0);
    step(1'b1, 24'h111111, 6'h3F);
    step(1'b1, 24'h222222, 6'h15);
    idle(28);

    // Invalid nibble and decimal point
    step(1'b1, 24'h00000C, 6'b000001);
    idle(30);

    // Leading-zero blanking on and off
    blank_lz = 1'b1;
    step(1'b1, 24'h091500, 6'd0);
    idle(30);
    blank_lz = 1'b0;
    idle(30);

    // Minute field selected for blinking
    blink_sel = 3'b010;
    idle(48);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if (k % 40 == 0) blink_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      rv = 24'($urandom);
      if ($urandom_range(0, 3) == 0) rv[23:20] = 4'd0;
      step($urandom_range(0, 3) == 0, rv, 6'($urandom));
    end

    // Reset mid-scan, then more random traffic from a clean state
    do_reset();
    for (int k = 0; k < 150; k++) begin
      rv = 24'($urandom);
      step($urandom_range(0, 4) == 0, rv, 6'($urandom));
    end

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
